// File: rtl/chip_vector_sequencer.sv
// Clocked stimulus/response sequencer for a combinational chip model: sweeps every
// {p1,p2} input combination, waits SETTLE cycles, and emits (vector, response) records.
module chip_vector_sequencer #(
  parameter int P1_W   = 6,
  parameter int P2_W   = 4,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [P1_W-1:0]      p1_out,
  output logic [P2_W-1:0]      p2_out,
  input  logic                 p1y_in,
  input  logic                 p2y_in,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [P1_W-1:0]      res_p1,
  output logic [P2_W-1:0]      res_p2,
  output logic                 res_p1y,
  output logic                 res_p2y,
  output logic                 busy,
  output logic                 done,
  output logic [P1_W+P2_W:0]   rec_count
);

  localparam int VW = P1_W + P2_W;
  localparam int CW = VW + 1;
  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_REPORT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  // {p1,p2} as one word: a single increment gives p2 as the inner loop, p1 as the outer.
  logic [VW-1:0] vec_q, vec_d;
  logic [VW-1:0] res_vec_q, res_vec_d;
  logic          res_p1y_q, res_p1y_d;
  logic          res_p2y_q, res_p2y_d;
  logic          res_valid_q, res_valid_d;
  logic [CW-1:0] rec_count_q, rec_count_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      vec_q       <= '0;
      res_vec_q   <= '0;
      res_p1y_q   <= 1'b0;
      res_p2y_q   <= 1'b0;
      res_valid_q <= 1'b0;
      rec_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vec_q       <= vec_d;
      res_vec_q   <= res_vec_d;
      res_p1y_q   <= res_p1y_d;
      res_p2y_q   <= res_p2y_d;
      res_valid_q <= res_valid_d;
      rec_count_q <= rec_count_d;
    end
  end

  // NOTE: every signal written here gets a hold default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vec_d       = vec_q;
    res_vec_d   = res_vec_q;
    res_p1y_d   = res_p1y_q;
    res_p2y_d   = res_p2y_q;
    res_valid_d = res_valid_q;
    rec_count_d = rec_count_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          vec_d       = '0;
          cnt_d       = SETTLE_M1;
          rec_count_d = '0;
          state_d     = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          res_vec_d   = vec_q;
          res_p1y_d   = p1y_in;
          res_p2y_d   = p2y_in;
          res_valid_d = 1'b1;
          state_d     = S_REPORT;
        end
      end
      S_REPORT: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          rec_count_d = rec_count_q + CW'(1);
          if (&vec_q) begin
            vec_d   = '0;
            state_d = S_DONE;
          end else begin
            vec_d   = vec_q + VW'(1);
            cnt_d   = SETTLE_M1;
            state_d = S_SETTLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign p1_out    = vec_q[VW-1:P2_W];
  assign p2_out    = vec_q[P2_W-1:0];
  assign res_p1    = res_vec_q[VW-1:P2_W];
  assign res_p2    = res_vec_q[P2_W-1:0];
  assign res_p1y   = res_p1y_q;
  assign res_p2y   = res_p2y_q;
  assign res_valid = res_valid_q;
  assign busy      = (state_q == S_SETTLE) || (state_q == S_REPORT);
  assign done      = (state_q == S_DONE);
  assign rec_count = rec_count_q;

endmodule

// File: tb/tb_chip_vector_sequencer.sv
// Directed bench for chip_vector_sequencer: small-width sweeps (plain, stalled, restarted,
// reset mid-record), a slow-settling chip with SETTLE=3, and a default-width sweep.
module tb_chip_vector_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: P1_W=2, P2_W=2, SETTLE=1, chip p1y=&p1, p2y=&p2
  logic       start_a, ready_a;
  logic [1:0] p1_out_a, p2_out_a, res_p1_a, res_p2_a;
  logic       res_valid_a, res_p1y_a, res_p2y_a, busy_a, done_a;
  logic [4:0] rec_count_a;

  chip_vector_sequencer #(.P1_W(2), .P2_W(2), .SETTLE(1)) u_a (
    .clk(clk), .reset(reset), .start(start_a),
    .p1_out(p1_out_a), .p2_out(p2_out_a),
    .p1y_in(&p1_out_a), .p2y_in(&p2_out_a),
    .res_valid(res_valid_a), .res_ready(ready_a),
    .res_p1(res_p1_a), .res_p2(res_p2_a), .res_p1y(res_p1y_a), .res_p2y(res_p2y_a),
    .busy(busy_a), .done(done_a), .rec_count(rec_count_a)
  );

  // Instance B: SETTLE=3, chip outputs p1y=p1[0]^p2[0], p2y=|p2 delayed by two cycles
  logic       start_b, ready_b;
  logic [1:0] p1_out_b, p2_out_b, res_p1_b, res_p2_b;
  logic       res_valid_b, res_p1y_b, res_p2y_b, busy_b, done_b;
  logic [4:0] rec_count_b;
  logic       y1_d1 = 1'b0, y1_d2 = 1'b0, y2_d1 = 1'b0, y2_d2 = 1'b0;

  always @(posedge clk) begin
    y1_d1 <= p1_out_b[0] ^ p2_out_b[0];
    y2_d1 <= |p2_out_b;
    y1_d2 <= y1_d1;
    y2_d2 <= y2_d1;
  end

  chip_vector_sequencer #(.P1_W(2), .P2_W(2), .SETTLE(3)) u_b (
    .clk(clk), .reset(reset), .start(start_b),
    .p1_out(p1_out_b), .p2_out(p2_out_b),
    .p1y_in(y1_d2), .p2y_in(y2_d2),
    .res_valid(res_valid_b), .res_ready(ready_b),
    .res_p1(res_p1_b), .res_p2(res_p2_b), .res_p1y(res_p1y_b), .res_p2y(res_p2y_b),
    .busy(busy_b), .done(done_b), .rec_count(rec_count_b)
  );

  // Instance C: default widths and settle time
  logic        start_c, ready_c;
  logic [5:0]  p1_out_c, res_p1_c;
  logic [3:0]  p2_out_c, res_p2_c;
  logic        res_valid_c, res_p1y_c, res_p2y_c, busy_c, done_c;
  logic [10:0] rec_count_c;

  chip_vector_sequencer u_c (
    .clk(clk), .reset(reset), .start(start_c),
    .p1_out(p1_out_c), .p2_out(p2_out_c),
    .p1y_in(&p1_out_c), .p2y_in(&p2_out_c),
    .res_valid(res_valid_c), .res_ready(ready_c),
    .res_p1(res_p1_c), .res_p2(res_p2_c), .res_p1y(res_p1y_c), .res_p2y(res_p2y_c),
    .busy(busy_c), .done(done_c), .rec_count(rec_count_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, "_vec"},   {28'd0, p1_out_a, p2_out_a}, 32'd0);
    check({tag, "_res"},   {26'd0, res_p1_a, res_p2_a, res_p1y_a, res_p2y_a}, 32'd0);
    check({tag, "_valid"}, {31'd0, res_valid_a}, 32'd0);
    check({tag, "_flags"}, {30'd0, busy_a, done_a}, 32'd0);
    check({tag, "_count"}, {27'd0, rec_count_a}, 32'd0);
  endtask

  // One full sweep of instance A. Inputs change and outputs are sampled at negedge.
  task automatic sweep_a(input int stall_idx, input int poke_idx, input int exp_cyc);
    int k = 0;
    int cyc = 0;
    int stall = 0;
    bit poked = 1'b0;
    logic [3:0] kv;
    start_a = 1'b1;
    ready_a = 1'b1;
    @(negedge clk);
    cyc = 1;
    start_a = 1'b0;
    check("a_start_busy",  {31'd0, busy_a}, 32'd1);
    check("a_start_done",  {31'd0, done_a}, 32'd0);
    check("a_start_count", {27'd0, rec_count_a}, 32'd0);
    while (!done_a && cyc < 300) begin
      ready_a = 1'b1;
      start_a = 1'b0;
      kv = 4'(k);
      if (res_valid_a) begin
        if (k == stall_idx && stall < 5) begin
          ready_a = 1'b0;
          stall++;
          check($sformatf("a_stall%0d_rec", stall), {28'd0, res_p1_a, res_p2_a}, {28'd0, kv});
          check($sformatf("a_stall%0d_p2out", stall), {30'd0, p2_out_a}, {30'd0, kv[1:0]});
          check($sformatf("a_stall%0d_count", stall), {27'd0, rec_count_a}, 32'(k));
        end else begin
          check($sformatf("a_rec%0d", k),
                {26'd0, res_p1_a, res_p2_a, res_p1y_a, res_p2y_a},
                {26'd0, kv, &kv[3:2], &kv[1:0]});
          check($sformatf("a_rec%0d_count", k), {27'd0, rec_count_a}, 32'(k));
          k++;
        end
      end else if (k == poke_idx && !poked) begin
        start_a = 1'b1;
        poked = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    check("a_done",       {31'd0, done_a}, 32'd1);
    check("a_done_cycle", 32'(cyc), 32'(exp_cyc));
    check("a_records",    32'(k), 32'd16);
    check("a_final_count", {27'd0, rec_count_a}, 32'd16);
    check("a_done_vec",   {28'd0, p1_out_a, p2_out_a}, 32'd0);
    check("a_done_busy",  {31'd0, busy_a}, 32'd0);
  endtask

  initial begin
    int k;
    int cyc;
    int last;
    logic [3:0] kv;
    logic [9:0] kc;

    reset   = 1'b1;
    start_a = 1'b0; ready_a = 1'b1;
    start_b = 1'b0; ready_b = 1'b1;
    start_c = 1'b0; ready_c = 1'b1;
    repeat (2) @(negedge clk);
    check_a_zero("a_reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_a_zero("a_idle_ready_ignored");

    // Plain sweep from IDLE with a start pulse while busy.
    sweep_a(-1, 6, 33);

    // DONE holds its final count without start.
    repeat (3) @(negedge clk);
    check("a_done_hold",       {31'd0, done_a}, 32'd1);
    check("a_done_hold_count", {27'd0, rec_count_a}, 32'd16);

    // Restart from DONE, stalling record 2 for five cycles.
    sweep_a(2, -1, 38);

    // Reset while record 5 is pending.
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    cyc = 0;
    while (!(res_valid_a && {res_p1_a, res_p2_a} == 4'd5) && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    ready_a = 1'b0;
    @(negedge clk);
    check("a_pend_valid", {31'd0, res_valid_a}, 32'd1);
    check("a_pend_rec",   {28'd0, res_p1_a, res_p2_a}, 32'd5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ready_a = 1'b1;
    check_a_zero("a_midreset");
    @(negedge clk);
    check_a_zero("a_after_reset");
    sweep_a(-1, -1, 33);

    // Slow chip: SETTLE=3, outputs lag the vector by two cycles.
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    k = 0; cyc = 1; last = 0;
    while (!done_b && cyc < 300) begin
      if (res_valid_b) begin
        kv = 4'(k);
        check($sformatf("b_rec%0d", k),
              {26'd0, res_p1_b, res_p2_b, res_p1y_b, res_p2y_b},
              {26'd0, kv, kv[2] ^ kv[0], |kv[1:0]});
        if (k == 0) check("b_first_valid_cycle", 32'(cyc), 32'd4);
        else        check($sformatf("b_spacing%0d", k), 32'(cyc - last), 32'd4);
        last = cyc;
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    check("b_done",    {31'd0, done_b}, 32'd1);
    check("b_records", 32'(k), 32'd16);
    check("b_count",   {27'd0, rec_count_b}, 32'd16);

    // Default widths.
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    k = 0; cyc = 1;
    while (!done_c && cyc < 5000) begin
      if (res_valid_c) begin
        kc = 10'(k);
        check($sformatf("c_rec%0d", k), {22'd0, res_p1_c, res_p2_c}, {22'd0, kc});
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    check("c_done",    {31'd0, done_c}, 32'd1);
    check("c_cycles",  32'(cyc), 32'd3073);
    check("c_count",   {21'd0, rec_count_c}, 32'd1024);
    check("c_last_p1", {26'd0, res_p1_c}, 32'd63);
    check("c_last_p2", {28'd0, res_p2_c}, 32'd15);
    check("c_last_y",  {30'd0, res_p1y_c, res_p2y_c}, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
